// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch PC generation, bimodal branch prediction and fetch queue
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module fetch_queue_unit #(
  parameter int FQ_DEPTH  = 4,
  parameter int BHT_IDX   = 8,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic [31:0] ic_pc,
  output logic        ic_req,
  input  logic        ic_valid,
  input  logic [31:0] ic_ins,
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_pc,
  output logic [31:0] dq_ins,
  output logic        dq_pred_jmp,
  output logic [31:0] dq_alt_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        jalr_done,
  input  logic [31:0] jalr_pc,
  input  logic        bp_upd,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken
);
  localparam int QW    = $clog2(FQ_DEPTH);
  localparam int BHT_N = 1 << BHT_IDX;
  localparam logic [QW:0]         FULL_CNT = (QW+1)'(FQ_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS-1));
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [31:0]         pc;
  logic                stuck;
  logic [31:0]         q_pc  [FQ_DEPTH];
  logic [31:0]         q_ins [FQ_DEPTH];
  logic [31:0]         q_alt [FQ_DEPTH];
  logic                q_pred[FQ_DEPTH];
  logic [QW-1:0]       head, tail;
  logic [QW:0]         count;
  logic [CNT_BITS-1:0] ctr [BHT_N];

  logic        is_c, is_jal, is_br, is_jalr, pred_bit, go_stuck, enq_pred;
  logic        accept, deq;
  logic [31:0] fall, jump_imm, br_imm, br_tgt, nxt_pc, enq_alt;
  logic [CNT_BITS-1:0] upd_cur, upd_nxt;
  logic        unused_bits;

  assign ic_pc       = pc;
  assign ic_req      = !stuck && (count < FULL_CNT);
  assign dq_valid    = (count != '0);
  assign dq_pc       = q_pc[head];
  assign dq_ins      = q_ins[head];
  assign dq_pred_jmp = q_pred[head];
  assign dq_alt_pc   = q_alt[head];
  assign accept      = ic_req && ic_valid;
  assign deq         = dq_valid && dq_ready;
  assign unused_bits = ^{ic_ins, bp_upd_pc};

  // Decode only what steers the PC: 32-bit opcodes, and RVC quadrant 01 / 10 jumps and branches.
  assign is_c    = (ic_ins[1:0] != 2'b11);
  assign is_jal  = is_c ? (ic_ins[1:0] == 2'b01 && (ic_ins[15:13] == 3'b101 || ic_ins[15:13] == 3'b001))
                        : (ic_ins[6:0] == 7'b1101111);
  assign is_br   = is_c ? (ic_ins[1:0] == 2'b01 && ic_ins[15:14] == 2'b11)
                        : (ic_ins[6:0] == 7'b1100011);
  assign is_jalr = is_c ? (ic_ins[1:0] == 2'b10 && ic_ins[15:13] == 3'b100 &&
                           ic_ins[11:7] != 5'd0 && ic_ins[6:2] == 5'd0)
                        : (ic_ins[6:0] == 7'b1100111);

  assign fall     = pc + (is_c ? 32'd2 : 32'd4);
  assign jump_imm = is_c ? {{20{ic_ins[12]}}, ic_ins[12], ic_ins[8], ic_ins[10:9], ic_ins[6], ic_ins[7],
                            ic_ins[2], ic_ins[11], ic_ins[5:3], 1'b0}
                         : {{12{ic_ins[31]}}, ic_ins[19:12], ic_ins[20], ic_ins[30:21], 1'b0};
  assign br_imm   = is_c ? {{23{ic_ins[12]}}, ic_ins[12], ic_ins[6:5], ic_ins[2], ic_ins[11:10],
                            ic_ins[4:3], 1'b0}
                         : {{20{ic_ins[31]}}, ic_ins[7], ic_ins[30:25], ic_ins[11:8], 1'b0};
  assign br_tgt   = pc + br_imm;
  assign pred_bit = ctr[pc[BHT_IDX:1]][CNT_BITS-1];

  assign upd_cur = ctr[bp_upd_pc[BHT_IDX:1]];
  assign upd_nxt = bp_upd_taken ? ((upd_cur == CNT_MAX) ? upd_cur : upd_cur + 1'b1)
                                : ((upd_cur == '0)      ? upd_cur : upd_cur - 1'b1);

`ifdef FETCH_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);
  logic [31:0]   ras [RAS_DEPTH];
  logic [RW-1:0] ras_ptr;
  logic [RW:0]   ras_cnt;
  logic          is_link, is_ret, ras_pop;
  logic [4:0]    rd, rs1;

  assign rd      = ic_ins[11:7];
  assign rs1     = is_c ? ic_ins[11:7] : ic_ins[19:15];
  assign is_link = is_c ? ((is_jal && ic_ins[15:13] == 3'b001) || (is_jalr && ic_ins[12]))
                        : ((is_jal || is_jalr) && (rd == 5'd1 || rd == 5'd5));
  assign is_ret  = is_jalr && (is_c ? (!ic_ins[12] && rs1 == 5'd1)
                                    : (rd == 5'd0 && (rs1 == 5'd1 || rs1 == 5'd5)));
`else
  localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
`endif

  always_comb begin
    nxt_pc   = fall;
    enq_pred = 1'b0;
    enq_alt  = fall;
    go_stuck = 1'b0;
`ifdef FETCH_RAS_EN
    ras_pop  = 1'b0;
`endif
    if (is_jal) begin
      nxt_pc   = pc + jump_imm;
      enq_pred = 1'b1;
    end else if (is_br) begin
      enq_pred = pred_bit;
      nxt_pc   = pred_bit ? br_tgt : fall;
      enq_alt  = pred_bit ? fall : br_tgt;
    end else if (is_jalr) begin
`ifdef FETCH_RAS_EN
      if (is_ret && ras_cnt != '0) begin
        nxt_pc   = ras[ras_ptr - 1'b1];
        enq_pred = 1'b1;
        ras_pop  = 1'b1;
      end else begin
        nxt_pc   = pc;
        go_stuck = 1'b1;
      end
`else
      nxt_pc   = pc;
      go_stuck = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pc    <= '0;
      stuck <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_ins[i]  <= '0;
        q_alt[i]  <= '0;
        q_pred[i] <= 1'b0;
      end
      for (int i = 0; i < BHT_N; i++) ctr[i] <= CNT_INIT;
`ifdef FETCH_RAS_EN
      ras_ptr <= '0;
      ras_cnt <= '0;
`endif
    end else if (rdy_in) begin
      // Prediction above already read the pre-update counter, so a same-index update is safe here.
      if (bp_upd) ctr[bp_upd_pc[BHT_IDX:1]] <= upd_nxt;
      if (rob_clear) begin
        pc    <= rob_new_pc;
        stuck <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
`ifdef FETCH_RAS_EN
        ras_ptr <= '0;
        ras_cnt <= '0;
`endif
      end else begin
        if (accept) begin
          q_pc[tail]   <= pc;
          q_ins[tail]  <= ic_ins;
          q_alt[tail]  <= enq_alt;
          q_pred[tail] <= enq_pred;
          tail         <= tail + 1'b1;
          pc           <= nxt_pc;
          if (go_stuck) stuck <= 1'b1;
`ifdef FETCH_RAS_EN
          // Circular stack: when full, the write slot is the oldest entry.
          if (is_link) begin
            ras[ras_ptr] <= fall;
            ras_ptr      <= ras_ptr + 1'b1;
            if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
          end else if (ras_pop) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
          end
`endif
        end else if (stuck && jalr_done) begin
          pc    <= jalr_pc;
          stuck <= 1'b0;
        end
        if (deq) head <= head + 1'b1;
        if (accept && !deq)      count <= count + 1'b1;
        else if (!accept && deq) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized bench for fetch_queue_unit against a queue-based model
module tb_fetch_queue_unit;
  localparam int FQ_DEPTH = 4, BHT_IDX = 8, CNT_BITS = 2, RAS_DEPTH = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in, rdy_in, ic_req, ic_valid, dq_valid, dq_ready, dq_pred_jmp;
  logic rob_clear, jalr_done, bp_upd, bp_upd_taken;
  logic [31:0] ic_pc, ic_ins, dq_pc, dq_ins, dq_alt_pc, rob_new_pc, jalr_pc, bp_upd_pc;

  fetch_queue_unit #(.FQ_DEPTH(FQ_DEPTH), .BHT_IDX(BHT_IDX), .CNT_BITS(CNT_BITS), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .ic_pc(ic_pc), .ic_req(ic_req),
    .ic_valid(ic_valid), .ic_ins(ic_ins), .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_pc(dq_pc),
    .dq_ins(dq_ins), .dq_pred_jmp(dq_pred_jmp), .dq_alt_pc(dq_alt_pc), .rob_clear(rob_clear),
    .rob_new_pc(rob_new_pc), .jalr_done(jalr_done), .jalr_pc(jalr_pc), .bp_upd(bp_upd),
    .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken));

  typedef enum int {K_ADDI, K_CADDI, K_JAL, K_CJ, K_CJAL, K_BR, K_CBR, K_JALR, K_CJR, K_CJALR} kind_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [31:0] alt; logic pred; } ent_t;

  ent_t        mq[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  bit          m_stuck;
  int          m_ctr[1 << BHT_IDX];
  kind_t       c_kind;
  logic [31:0] c_imm;
  logic [4:0]  c_rd, c_rs1;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [31:0] encode(kind_t k, logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1,
                                         logic [15:0] hi);
    case (k)
      K_ADDI:  return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      K_CADDI: return {hi, 3'b000, imm[5], rd, imm[4:0], 2'b01};
      K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      K_CJ:    return {hi, 3'b101, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
      K_CJAL:  return {hi, 3'b001, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
      K_BR:    return {imm[12], imm[10:5], rs1, rd, hi[2:0], imm[4:1], imm[11], 7'b1100011};
      K_CBR:   return {hi, 2'b11, hi[3], imm[8], imm[4:3], rs1[2:0], imm[7:6], imm[2:1], imm[5], 2'b01};
      K_JALR:  return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      K_CJR:   return {hi, 3'b100, 1'b0, rs1, 5'd0, 2'b10};
      default: return {hi, 3'b100, 1'b1, rs1, 5'd0, 2'b10};
    endcase
  endfunction

  task automatic set_ins(kind_t k, logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1);
    c_kind = k; c_imm = imm; c_rd = rd; c_rs1 = rs1;
    ic_ins = encode(k, imm, rd, rs1, 16'($urandom));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_stuck = 0; mq.delete(); m_ras.delete();
    foreach (m_ctr[i]) m_ctr[i] = 2 ** (CNT_BITS - 1);
  endtask

  // Advances the model by one clock using the inputs that were present at the edge.
  task automatic model_step();
    int  idx, uidx;
    bit  pred, req, acc, deq, link, ret;
    logic [31:0] fall, tgt;
    ent_t e;
    if (!rst_n_in) begin model_reset(); return; end
    if (!rdy_in) return;
    idx  = int'(m_pc[BHT_IDX:1]);
    pred = (m_ctr[idx] >= 2 ** (CNT_BITS - 1));
    if (bp_upd) begin
      uidx = int'(bp_upd_pc[BHT_IDX:1]);
      if (bp_upd_taken) m_ctr[uidx] = (m_ctr[uidx] + 1 > 2 ** CNT_BITS - 1) ? 2 ** CNT_BITS - 1 : m_ctr[uidx] + 1;
      else              m_ctr[uidx] = (m_ctr[uidx] == 0) ? 0 : m_ctr[uidx] - 1;
    end
    if (rob_clear) begin
      m_pc = rob_new_pc; m_stuck = 0; mq.delete(); m_ras.delete();
      return;
    end
    req = !m_stuck && mq.size() < FQ_DEPTH;
    acc = req && ic_valid;
    deq = mq.size() > 0 && dq_ready;
    if (deq) void'(mq.pop_front());
    if (acc) begin
      fall = m_pc + ((c_kind inside {K_ADDI, K_JAL, K_BR, K_JALR}) ? 32'd4 : 32'd2);
      tgt  = m_pc + c_imm;
      e.pc = m_pc; e.ins = ic_ins; e.alt = fall; e.pred = 0;
      link = 0; ret = 0;
`ifdef FETCH_RAS_EN
      link = (c_kind inside {K_JAL, K_JALR} && (c_rd == 1 || c_rd == 5)) || c_kind inside {K_CJAL, K_CJALR};
      ret  = (c_kind == K_JALR && c_rd == 0 && (c_rs1 == 1 || c_rs1 == 5)) || (c_kind == K_CJR && c_rs1 == 1);
`endif
      case (c_kind)
        K_JAL, K_CJ, K_CJAL: begin e.pred = 1; m_pc = tgt; end
        K_BR, K_CBR: begin
          e.pred = pred;
          m_pc   = pred ? tgt : fall;
          e.alt  = pred ? fall : tgt;
        end
        K_JALR, K_CJR, K_CJALR: begin
          if (ret && m_ras.size() > 0) begin
            e.pred = 1; m_pc = m_ras.pop_back();
          end else m_stuck = 1;
        end
        default: m_pc = fall;
      endcase
      if (link) begin
        if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(fall);
      end
      mq.push_back(e);
    end else if (m_stuck && jalr_done) begin
      m_pc = jalr_pc; m_stuck = 0;
    end
  endtask

  task automatic compare();
    chk("ic_pc", ic_pc, m_pc);
    chk("ic_req", 32'(ic_req), 32'(!m_stuck && mq.size() < FQ_DEPTH));
    chk("dq_valid", 32'(dq_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("dq_pc", dq_pc, mq[0].pc);
      chk("dq_ins", dq_ins, mq[0].ins);
      chk("dq_pred_jmp", 32'(dq_pred_jmp), 32'(mq[0].pred));
      chk("dq_alt_pc", dq_alt_pc, mq[0].alt);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    compare();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic rand_ins();
    int r = $urandom_range(0, 15);
    kind_t k = (r > 9) ? K_ADDI : kind_t'(r);
    logic [31:0] imm;
    logic [4:0] rs1 = pick_reg();
    case (k)
      K_JAL:        imm = 32'((int'($urandom_range(0, 2**20 - 1)) - 2**19) * 2);
      K_BR:         imm = 32'((int'($urandom_range(0, 2**12 - 1)) - 2**11) * 2);
      K_CJ, K_CJAL: imm = 32'((int'($urandom_range(0, 2**11 - 1)) - 2**10) * 2);
      K_CBR:        imm = 32'((int'($urandom_range(0, 2**8 - 1)) - 2**7) * 2);
      default:      imm = $urandom;
    endcase
    if (k inside {K_CJR, K_CJALR} && rs1 == 0) rs1 = 5'd1;
    set_ins(k, imm, pick_reg(), rs1);
  endtask

  initial begin
    rst_n_in = 0; rdy_in = 1; ic_valid = 1; dq_ready = 1; rob_clear = 0; rob_new_pc = 0;
    jalr_done = 0; jalr_pc = 0; bp_upd = 0; bp_upd_pc = 0; bp_upd_taken = 0;
    set_ins(K_ADDI, 0, 0, 0);
    model_reset();
    step(); step();
    chk("rst_ic_pc", ic_pc, 32'h0);
    chk("rst_ic_req", 32'(ic_req), 32'd1);
    chk("rst_dq_valid", 32'(dq_valid), 32'd0);
    chk("rst_dq_pc", dq_pc, 32'h0);
    chk("rst_dq_ins", dq_ins, 32'h0);
    chk("rst_dq_alt", dq_alt_pc, 32'h0);
    chk("rst_dq_pred", 32'(dq_pred_jmp), 32'd0);
    chk("nop_enc", ic_ins, 32'h00000013);

    rst_n_in = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("nop_ic_pc", ic_pc, 32'(4 * k));
      chk("nop_dq_pc", dq_pc, 32'(4 * (k - 1)));
    end
    set_ins(K_BR, 32'd8, 5'd2, 5'd3);
    step();
    chk("beq_ic_pc", ic_pc, 32'h18);
    chk("beq_pred", 32'(dq_pred_jmp), 32'd1);
    chk("beq_alt", dq_alt_pc, 32'h14);
    rob_clear = 1; rob_new_pc = 32'h10; bp_upd = 1; bp_upd_pc = 32'h10; bp_upd_taken = 0;
    step();
    chk("clr_ic_pc", ic_pc, 32'h10);
    chk("clr_dq_valid", 32'(dq_valid), 32'd0);
    rob_clear = 0; ic_valid = 0;
    step();
    bp_upd = 0; ic_valid = 1;
    set_ins(K_BR, 32'd8, 5'd2, 5'd3);
    step();
    chk("bnt_ic_pc", ic_pc, 32'h14);
    chk("bnt_pred", 32'(dq_pred_jmp), 32'd0);
    chk("bnt_alt", dq_alt_pc, 32'h18);

    set_ins(K_JALR, 32'd0, 5'd0, 5'd2);
    step();
    chk("jalr_req", 32'(ic_req), 32'd0);
    set_ins(K_ADDI, 0, 0, 0);
    step(); step();
    chk("stuck_req", 32'(ic_req), 32'd0);
    chk("stuck_pc", ic_pc, 32'h14);
    jalr_done = 1; jalr_pc = 32'h100;
    step();
    jalr_done = 0;
    chk("resume_pc", ic_pc, 32'h100);
    chk("resume_req", 32'(ic_req), 32'd1);
    set_ins(K_JALR, 32'd0, 5'd0, 5'd2);
    step();
    rob_clear = 1; rob_new_pc = 32'h300;
    step();
    rob_clear = 0;
    chk("stuck_clr_pc", ic_pc, 32'h300);

    set_ins(K_ADDI, 0, 0, 0);
    dq_ready = 0;
    repeat (6) step();
    chk("full_req", 32'(ic_req), 32'd0);
    chk("full_pc", ic_pc, 32'h310);
    dq_ready = 1;
    step();
    chk("drain_req", 32'(ic_req), 32'd1);
    rob_clear = 1; rob_new_pc = 32'h80; bp_upd = 1; bp_upd_pc = 32'h10; bp_upd_taken = 1;
    step();
    rob_clear = 0; bp_upd = 0;
    chk("clr3_valid", 32'(dq_valid), 32'd0);
    chk("clr3_pc", ic_pc, 32'h80);

`ifdef FETCH_RAS_EN
    rob_clear = 1; rob_new_pc = 32'h40;
    step();
    rob_clear = 0;
    set_ins(K_JAL, 32'h1c0, 5'd1, 5'd0);
    step();
    chk("ras_call_pc", ic_pc, 32'h200);
    set_ins(K_JALR, 32'd0, 5'd0, 5'd1);
    step();
    chk("ras_ret_pc", ic_pc, 32'h44);
    chk("ras_ret_req", 32'(ic_req), 32'd1);
    chk("ras_ret_pred", 32'(dq_pred_jmp), 32'd1);
`endif

    for (int cyc = 0; cyc < 5000; cyc++) begin
      rst_n_in     = ($urandom_range(0, 799) != 0);
      rdy_in       = ($urandom_range(0, 9) != 0);
      ic_valid     = ($urandom_range(0, 3) != 0);
      dq_ready     = ($urandom_range(0, 2) != 0);
      rob_clear    = ($urandom_range(0, 39) == 0);
      rob_new_pc   = ($urandom_range(0, 7) == 0) ? 32'hfffffff0 : 32'($urandom_range(0, 2047)) & ~32'd1;
      jalr_done    = ($urandom_range(0, 5) == 0);
      jalr_pc      = 32'($urandom_range(0, 2047)) & ~32'd1;
      bp_upd       = ($urandom_range(0, 2) == 0);
      bp_upd_pc    = 32'($urandom_range(0, 2047));
      bp_upd_taken = 1'($urandom);
      rand_ins();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
